// File: rtl/inst_fetch_buffer_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch buffer.
// slave: seen by the buffer itself; master: seen by the surrounding pipeline.
interface inst_fetch_buffer_if #(
  parameter int unsigned DEPTH = 2
) ();

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            in_valid;
  logic [31:0]     in_inst;
  logic [31:0]     in_pc;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [31:0]     out_pc;
  logic [2:0]      out_imm_type;
  logic [CntW-1:0] out_count;

  modport slave (
    input  flush,
    input  in_valid,
    input  in_inst,
    input  in_pc,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output out_imm_type,
    output out_count
  );

  modport master (
    output flush,
    output in_valid,
    output in_inst,
    output in_pc,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  out_imm_type,
    input  out_count
  );

endinterface

// File: rtl/inst_fetch_buffer.sv
// Small FIFO between fetch and decode. Head entry is always presented from
// storage (no input bypass) together with its decoded immediate type.
module inst_fetch_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_fetch_buffer_if.slave   bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  // Immediate-type codes shared with the immediate generator.
  localparam logic [2:0] ImmR = 3'd0;
  localparam logic [2:0] ImmI = 3'd1;
  localparam logic [2:0] ImmS = 3'd2;
  localparam logic [2:0] ImmB = 3'd3;
  localparam logic [2:0] ImmU = 3'd4;
  localparam logic [2:0] ImmJ = 3'd5;

  logic [31:0]     inst_q [DEPTH];
  logic [31:0]     pc_q   [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  logic [31:0]     head_inst;
  logic [2:0]      imm_type;

  // Handshake qualification; flush suppresses both sides.
  always_comb begin
    bus.in_ready  = (count_q < CntW'(DEPTH));
    bus.out_valid = (count_q != '0);
    push          = bus.in_valid && bus.in_ready && !bus.flush;
    pop           = bus.out_valid && bus.out_ready && !bus.flush;
  end

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are never cleared, only invalidated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr_q] <= bus.in_inst;
      pc_q[wr_ptr_q]   <= bus.in_pc;
    end
  end

  // Immediate-type decode of the head opcode; unknown opcodes fall back to R.
  always_comb begin
    head_inst = inst_q[rd_ptr_q];
    imm_type  = ImmR;
    case (head_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: imm_type = ImmI;
      7'b0110011:                         imm_type = ImmR;
      7'b0110111, 7'b0010111:             imm_type = ImmU;
      7'b1100011:                         imm_type = ImmB;
      7'b0100011:                         imm_type = ImmS;
      7'b1101111:                         imm_type = ImmJ;
      default:                            imm_type = ImmR;
    endcase
  end

  // Head outputs.
  always_comb begin
    bus.out_inst     = head_inst;
    bus.out_pc       = pc_q[rd_ptr_q];
    bus.out_imm_type = imm_type;
    bus.out_count    = count_q;
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer (DEPTH=2).
module tb_inst_fetch_buffer;

  localparam logic [31:0] ImmR = 32'd0;
  localparam logic [31:0] ImmI = 32'd1;
  localparam logic [31:0] ImmS = 32'd2;
  localparam logic [31:0] ImmB = 32'd3;
  localparam logic [31:0] ImmU = 32'd4;
  localparam logic [31:0] ImmJ = 32'd5;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  inst_fetch_buffer_if #(.DEPTH(2)) bus ();

  inst_fetch_buffer #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  logic [31:0] stream_inst [8];
  logic [31:0] stream_type [8];

  initial begin
    checks = 0;
    errors = 0;
    stream_inst = '{32'h00500093, 32'h002081B3, 32'h000012B7, 32'h00812023,
                    32'h0000006F, 32'h00002003, 32'h000080E7, 32'hFE000EE3};
    stream_type = '{ImmI, ImmR, ImmU, ImmS, ImmJ, ImmI, ImmI, ImmB};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_count", {30'b0, bus.out_count}, 32'd0);

    // First push after reset appears next cycle.
    rst_n = 1'b1;
    drive(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("p1_valid", {31'b0, bus.out_valid}, 32'd1);
    check("p1_inst", bus.out_inst, 32'h00500093);
    check("p1_imm", {29'b0, bus.out_imm_type}, ImmI);
    check("p1_count", {30'b0, bus.out_count}, 32'd1);

    // Empty via flush, then fill to full and try a third push.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check("fl0_count", {30'b0, bus.out_count}, 32'd0);
    drive(1'b1, 32'h00000013, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00100073, 32'h4, 1'b0, 1'b0);
    tick();
    check("full_ready", {31'b0, bus.in_ready}, 32'd0);
    check("full_count", {30'b0, bus.out_count}, 32'd2);
    drive(1'b1, 32'hDEADBEEF, 32'h8, 1'b0, 1'b0);
    tick();
    check("ovf_count", {30'b0, bus.out_count}, 32'd2);
    check("ovf_head", bus.out_inst, 32'h00000013);
    check("ovf_pc", bus.out_pc, 32'h0);
    check("ovf_imm", {29'b0, bus.out_imm_type}, ImmI);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("pop_head", bus.out_inst, 32'h00100073);
    check("pop_pc", bus.out_pc, 32'h4);
    check("pop_imm", {29'b0, bus.out_imm_type}, ImmR);
    check("pop_count", {30'b0, bus.out_count}, 32'd1);

    // Simultaneous push/pop at count==1.
    drive(1'b1, 32'hFE000EE3, 32'h8, 1'b1, 1'b0);
    tick();
    check("pp_count", {30'b0, bus.out_count}, 32'd1);
    check("pp_head", bus.out_inst, 32'hFE000EE3);
    check("pp_imm", {29'b0, bus.out_imm_type}, ImmB);

    // Fill to two, head holds while stalled, then flush with push+pop pending.
    drive(1'b1, 32'h00000517, 32'h10, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("st_count", {30'b0, bus.out_count}, 32'd2);
    tick();
    check("st_hold", bus.out_inst, 32'hFE000EE3);
    check("st_pc", bus.out_pc, 32'h8);
    drive(1'b1, 32'h12345037, 32'h14, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("fl_count", {30'b0, bus.out_count}, 32'd0);
    check("fl_valid", {31'b0, bus.out_valid}, 32'd0);
    check("fl_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    check("fl_drop", {30'b0, bus.out_count}, 32'd0);

    // Full-rate stream across pointer wrap.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, stream_inst[i], 32'(i * 4), 1'b1, 1'b0);
      tick();
      check($sformatf("s%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
      check($sformatf("s%0d_pc", i), bus.out_pc, 32'(i * 4));
      check($sformatf("s%0d_inst", i), bus.out_inst, stream_inst[i]);
      check($sformatf("s%0d_imm", i), {29'b0, bus.out_imm_type}, stream_type[i]);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("s_drain", {30'b0, bus.out_count}, 32'd0);

    // Asynchronous reset mid-operation with two entries buffered.
    drive(1'b1, 32'h00000093, 32'h20, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00000113, 32'h24, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("ar_pre", {30'b0, bus.out_count}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, bus.out_valid}, 32'd0);
    check("ar_count", {30'b0, bus.out_count}, 32'd0);
    check("ar_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 32'hABCDE037, 32'h40, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("ar_count1", {30'b0, bus.out_count}, 32'd1);
    check("ar_head", bus.out_inst, 32'hABCDE037);
    check("ar_pc", bus.out_pc, 32'h40);
    check("ar_imm", {29'b0, bus.out_imm_type}, ImmU);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
